// File: rtl/if_id_stage_pkg.sv
// if_id_stage_pkg: instruction field positions, FSM encoding and default halt opcode for if_id_stage.
package if_id_stage_pkg;
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam logic [5:0] HALT_OP_DEFAULT = 6'b111111;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
endpackage

// File: rtl/if_id_stage_pc_reg.sv
// pc_reg: program counter with priority rst > load > hold > increment, wrapping modulo 2^ADDR_W.
module pc_reg #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              hold,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= RESET_PC;
    else if (load) pc <= target;
    else if (!hold) pc <= pc + ADDR_W'(PC_STEP);
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: PC owner and IF/ID pipeline register with stall, branch flush and terminal HALT.
// Optional IFID_PERF_CNT_EN adds saturating retired_cnt/stall_cnt outputs.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4,
  parameter logic [5:0] HALT_OPCODE = HALT_OP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [31:0]       imem_data,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              id_valid,
  output logic [5:0]        id_opcode,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [15:0]       id_imm16,
  output logic [ADDR_W-1:0] id_pc4,
  output logic              halted
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       stall_cnt
`endif
);
  state_t state, state_nx;
  logic run, latch, is_halt;
  logic [ADDR_W-1:0] pc;
  assign run = state == RUN;
  assign latch = run && !br_taken && !stall;
  assign is_halt = imem_data[OPCODE_HI:OPCODE_LO] == HALT_OPCODE;
  assign imem_addr = pc;
  assign halted = state == HALT;
  always_comb
    state_nx = state == BOOT ? RUN : (latch && is_halt) ? HALT : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= BOOT;
    else state <= state_nx;
  // a latched halt instruction keeps the PC pointing at itself
  pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc (
    .clk(clk),
    .rst(rst),
    .load(run && br_taken),
    .hold(!latch || is_halt),
    .target(br_target),
    .pc(pc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      id_valid <= 1'b0;
      id_opcode <= '0;
      id_rs <= '0;
      id_rt <= '0;
      id_imm16 <= '0;
      id_pc4 <= '0;
    end else if (latch) begin
      id_valid <= 1'b1;
      id_opcode <= imem_data[OPCODE_HI:OPCODE_LO];
      id_rs <= imem_data[RS_HI:RS_LO];
      id_rt <= imem_data[RT_HI:RT_LO];
      id_imm16 <= imem_data[IMM_HI:IMM_LO];
      id_pc4 <= pc + ADDR_W'(PC_STEP);
    end else if ((run && br_taken) || halted) id_valid <= 1'b0;
`ifdef IFID_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      retired_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      retired_cnt <= (latch && retired_cnt != '1) ? retired_cnt + 32'd1 : retired_cnt;
      stall_cnt <= (run && stall && !br_taken && stall_cnt != '1) ? stall_cnt + 32'd1 : stall_cnt;
    end
`endif
endmodule
